// File: rtl/xswitch_mst_bridge.sv
// xswitch_mst_bridge: master-side switch adapter with request FIFO, in-flight limiter and 1-entry response slice.
// Revision: 1.0
`default_nettype none

module xswitch_mst_bridge #(
  parameter int REQ_W    = 66,
  parameter int RSP_W    = 37,
  parameter int DEPTH    = 4,
  parameter int MAX_OUTS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            m_req_vld,
  input  logic [REQ_W-1:0]                m_req_pkt,
  output logic                            m_req_gnt,
  output logic                            m_rsp_vld,
  output logic [RSP_W-1:0]                m_rsp_pkt,
  input  logic                            m_rsp_gnt,
  output logic                            x_req_vld,
  output logic [REQ_W-1:0]                x_req_pkt,
  input  logic                            x_req_gnt,
  input  logic                            x_rsp_vld,
  input  logic [RSP_W-1:0]                x_rsp_pkt,
  output logic                            x_rsp_gnt,
  output logic [$clog2(MAX_OUTS+1)-1:0]   inflight,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_lvl,
  output logic                            err_unexp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(MAX_OUTS+1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTS);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slice_full_q, slice_full_d;
  logic [RSP_W-1:0] slice_pkt_q, slice_pkt_d;
  logic             err_q, err_d;

  logic push, pop, rsp_in, rsp_out;

  // Grant depends only on registered state so the master never sees a vld->gnt loop.
  assign m_req_gnt = !rst && (lvl_q < LVL_FULL) && (cnt_q < CNT_MAX);
  assign push      = m_req_vld && m_req_gnt;
  assign x_req_vld = (lvl_q != '0);
  assign x_req_pkt = mem_q[rd_ptr_q];
  assign pop       = x_req_vld && x_req_gnt;

  assign x_rsp_gnt = !rst && (!slice_full_q || m_rsp_gnt);
  assign rsp_in    = x_rsp_vld && x_rsp_gnt;
  assign m_rsp_vld = slice_full_q;
  assign m_rsp_pkt = slice_pkt_q;
  assign rsp_out   = slice_full_q && m_rsp_gnt;

  assign inflight  = cnt_q;
  assign fifo_lvl  = lvl_q;
  assign err_unexp = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
    // An unexpected response delivered at zero leaves the counter at zero.
    case ({push, rsp_out})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    slice_full_d = rsp_in || (slice_full_q && !m_rsp_gnt);
    slice_pkt_d  = rsp_in ? x_rsp_pkt : slice_pkt_q;
    err_d        = err_q || (rsp_in && (cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lvl_q        <= '0;
      cnt_q        <= '0;
      slice_full_q <= 1'b0;
      slice_pkt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lvl_q        <= lvl_d;
      cnt_q        <= cnt_d;
      slice_full_q <= slice_full_d;
      slice_pkt_q  <= slice_pkt_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= m_req_pkt;
  end

endmodule

`default_nettype wire

// File: tb/tb_xswitch_mst_bridge.sv
// Testbench for xswitch_mst_bridge: directed scenarios plus random traffic against a queue-based model.
`default_nettype none

module tb_xswitch_mst_bridge;

  localparam int REQ_W    = 66;
  localparam int RSP_W    = 37;
  localparam int DEPTH    = 4;
  localparam int MAX_OUTS = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_req_vld;
  logic [REQ_W-1:0] m_req_pkt;
  logic             m_req_gnt;
  logic             m_rsp_vld;
  logic [RSP_W-1:0] m_rsp_pkt;
  logic             m_rsp_gnt;
  logic             x_req_vld;
  logic [REQ_W-1:0] x_req_pkt;
  logic             x_req_gnt;
  logic             x_rsp_vld;
  logic [RSP_W-1:0] x_rsp_pkt;
  logic             x_rsp_gnt;
  logic [3:0]       inflight;
  logic [2:0]       fifo_lvl;
  logic             err_unexp;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [REQ_W-1:0] fq[$];
  logic [RSP_W-1:0] sq[$];
  int               infl = 0;
  bit               err  = 1'b0;
  bit               last_push, last_rin;

  always #5 clk = ~clk;

  xswitch_mst_bridge #(
    .REQ_W(REQ_W), .RSP_W(RSP_W), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_vld(m_req_vld), .m_req_pkt(m_req_pkt), .m_req_gnt(m_req_gnt),
    .m_rsp_vld(m_rsp_vld), .m_rsp_pkt(m_rsp_pkt), .m_rsp_gnt(m_rsp_gnt),
    .x_req_vld(x_req_vld), .x_req_pkt(x_req_pkt), .x_req_gnt(x_req_gnt),
    .x_rsp_vld(x_rsp_vld), .x_rsp_pkt(x_rsp_pkt), .x_rsp_gnt(x_rsp_gnt),
    .inflight(inflight), .fifo_lvl(fifo_lvl), .err_unexp(err_unexp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_mgnt();
    return !rst && (fq.size() < DEPTH) && (infl < MAX_OUTS);
  endfunction

  function automatic bit exp_xrgnt();
    return !rst && ((sq.size() == 0) || m_rsp_gnt);
  endfunction

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[REQ_W-1:0];
  endfunction

  function automatic logic [RSP_W-1:0] rnd_rsp();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[RSP_W-1:0];
  endfunction

  // Mid-cycle sample of every output against the model.
  task automatic sample();
    @(negedge clk);
    chk("m_req_gnt", 128'(m_req_gnt), 128'(exp_mgnt()));
    chk("x_req_vld", 128'(x_req_vld), 128'(fq.size() != 0));
    if (fq.size() != 0) chk("x_req_pkt", 128'(x_req_pkt), 128'(fq[0]));
    chk("x_rsp_gnt", 128'(x_rsp_gnt), 128'(exp_xrgnt()));
    chk("m_rsp_vld", 128'(m_rsp_vld), 128'(sq.size() != 0));
    if (sq.size() != 0) chk("m_rsp_pkt", 128'(m_rsp_pkt), 128'(sq[0]));
    chk("inflight", 128'(inflight), 128'(infl));
    chk("fifo_lvl", 128'(fifo_lvl), 128'(fq.size()));
    chk("err_unexp", 128'(err_unexp), 128'(err));
  endtask

  // Advance one clock edge and apply the transfers to the model.
  task automatic step();
    bit push_e, pop_e, rin_e, rout_e;
    push_e = m_req_vld && exp_mgnt();
    pop_e  = (fq.size() != 0) && x_req_gnt;
    rin_e  = x_rsp_vld && exp_xrgnt();
    rout_e = (sq.size() != 0) && m_rsp_gnt;
    @(posedge clk);
    if (rst) begin
      fq.delete();
      sq.delete();
      infl   = 0;
      err    = 1'b0;
      push_e = 1'b0;
      rin_e  = 1'b0;
    end else begin
      if (rin_e && infl == 0) err = 1'b1;
      if (pop_e)  void'(fq.pop_front());
      if (push_e) fq.push_back(m_req_pkt);
      if (rout_e) void'(sq.pop_front());
      if (rin_e)  sq.push_back(x_rsp_pkt);
      infl = infl + int'(push_e) - int'(rout_e);
      if (infl < 0) infl = 0;
    end
    last_push = push_e;
    last_rin  = rin_e;
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  initial begin
    int acc;
    logic [RSP_W-1:0] p1, p2, p3, p4;

    rst = 1'b1; m_req_vld = 1'b1; m_req_pkt = rnd_req(); m_rsp_gnt = 1'b1;
    x_req_gnt = 1'b0; x_rsp_vld = 1'b0; x_rsp_pkt = '0;

    // Reset held two cycles with a pending request
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_m_req_gnt", 128'(m_req_gnt), 128'(0));
      chk("rst_x_req_vld", 128'(x_req_vld), 128'(0));
      chk("rst_x_rsp_gnt", 128'(x_rsp_gnt), 128'(0));
      step();
    end
    rst = 1'b0; m_req_vld = 1'b0;
    sample();
    chk("rel_m_req_gnt", 128'(m_req_gnt), 128'(1));
    step();

    // Fill FIFO with the switch stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      m_req_vld = 1'b1; m_req_pkt = REQ_W'(10 + i);
      cyc();
    end
    m_req_vld = 1'b0;
    sample();
    chk("full_lvl", 128'(fifo_lvl), 128'(4));
    chk("full_gnt", 128'(m_req_gnt), 128'(0));
    step();
    x_req_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("order_vld", 128'(x_req_vld), 128'(1));
      chk("order_pkt", 128'(x_req_pkt), 128'(10 + i));
      step();
    end

    // In-flight limit: 4 outstanding already, exactly 4 more accepted
    acc = 0;
    m_req_vld = 1'b1; m_req_pkt = rnd_req();
    for (int i = 0; i < 10; i++) begin
      sample();
      if (m_req_gnt) acc++;
      step();
      if (last_push) m_req_pkt = rnd_req();
    end
    chk("max_acc", 128'(acc), 128'(4));
    sample();
    chk("max_inflight", 128'(inflight), 128'(8));
    chk("max_gnt", 128'(m_req_gnt), 128'(0));
    step();
    x_rsp_vld = 1'b1; x_rsp_pkt = rnd_rsp(); m_rsp_gnt = 1'b1;
    cyc();
    x_rsp_vld = 1'b0;
    cyc();
    sample();
    chk("dec_inflight", 128'(inflight), 128'(7));
    chk("dec_gnt", 128'(m_req_gnt), 128'(1));
    step();
    m_req_vld = 1'b0;

    // Bring in-flight down to 3, then accept and deliver in the same cycle
    x_rsp_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_rsp_pkt = rnd_rsp();
      cyc();
    end
    x_rsp_vld = 1'b0;
    cyc();
    x_rsp_vld = 1'b1; x_rsp_pkt = rnd_rsp();
    cyc();
    x_rsp_vld = 1'b0; m_req_vld = 1'b1; m_req_pkt = rnd_req();
    sample();
    chk("same_pre_inflight", 128'(inflight), 128'(3));
    chk("same_pre_gnt", 128'(m_req_gnt), 128'(1));
    chk("same_pre_rsp", 128'(m_rsp_vld), 128'(1));
    step();
    m_req_vld = 1'b0;
    sample();
    chk("same_post_inflight", 128'(inflight), 128'(3));
    step();

    // Response backpressure through the slice
    p1 = rnd_rsp(); p2 = rnd_rsp(); p3 = rnd_rsp(); p4 = rnd_rsp();
    m_rsp_gnt = 1'b0; x_rsp_vld = 1'b1; x_rsp_pkt = p1;
    sample(); chk("bp_gnt0", 128'(x_rsp_gnt), 128'(1)); step();
    x_rsp_pkt = p2;
    sample(); chk("bp_hold_pkt", 128'(m_rsp_pkt), 128'(p1)); chk("bp_gnt1", 128'(x_rsp_gnt), 128'(0)); step();
    sample(); chk("bp_gnt2", 128'(x_rsp_gnt), 128'(0)); step();
    m_rsp_gnt = 1'b1;
    sample(); chk("bp_gnt3", 128'(x_rsp_gnt), 128'(1)); chk("bp_p1", 128'(m_rsp_pkt), 128'(p1)); step();
    x_rsp_pkt = p3;
    sample(); chk("bp_p2", 128'(m_rsp_pkt), 128'(p2)); chk("bp_gnt4", 128'(x_rsp_gnt), 128'(1)); step();
    x_rsp_vld = 1'b0;
    sample(); chk("bp_p3", 128'(m_rsp_pkt), 128'(p3)); step();
    sample(); chk("bp_empty", 128'(m_rsp_vld), 128'(0)); chk("bp_inflight", 128'(inflight), 128'(0)); step();

    // Unexpected response with nothing in flight
    x_rsp_vld = 1'b1; x_rsp_pkt = p4;
    cyc();
    x_rsp_vld = 1'b0;
    sample();
    chk("unexp_fwd", 128'(m_rsp_pkt), 128'(p4));
    chk("unexp_err", 128'(err_unexp), 128'(1));
    step();
    sample();
    chk("unexp_inflight", 128'(inflight), 128'(0));
    chk("unexp_sticky", 128'(err_unexp), 128'(1));
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!m_req_vld || last_push) begin
        m_req_vld = 1'($urandom_range(0, 1));
        m_req_pkt = rnd_req();
      end
      if (!x_rsp_vld || last_rin) begin
        x_rsp_vld = ($urandom_range(0, 2) == 0);
        x_rsp_pkt = rnd_rsp();
      end
      x_req_gnt = ($urandom_range(0, 3) != 0);
      m_rsp_gnt = ($urandom_range(0, 2) != 0);
      cyc();
    end

    // Mid-operation reset clears everything including the sticky error
    rst = 1'b1;
    cyc();
    m_req_vld = 1'b0; x_rsp_vld = 1'b0;
    cyc();
    rst = 1'b0;
    sample();
    chk("final_err", 128'(err_unexp), 128'(0));
    chk("final_lvl", 128'(fifo_lvl), 128'(0));
    chk("final_inflight", 128'(inflight), 128'(0));
    chk("final_rsp_vld", 128'(m_rsp_vld), 128'(0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
